uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Receive-side framing stage that sits directly downstream of the UART receiver and consumes its `uart_rdata` / `uart_rdata_valid` / `uart_rdata_error` byte stream. It finds framed packets (`HEAD0 HEAD1 LEN PAYLOAD[LEN] CHK`), forwards payload bytes cut-through with a last-byte marker, and reports a per-frame result. The result is either checksum OK, or one of bad checksum, bad length, or timeout/line error. Downstream logic (command decoder, TX response builder) must treat the payload as provisional until `frame_done` with `frame_ok=1`.

## Interface
Parameters:
- `CLK_FREQ_MHZ`, 100: clock frequency in MHz.
- `TIMEOUT_US`, 1000: maximum gap between bytes inside a frame, in µs. `TIMEOUT_CYC = CLK_FREQ_MHZ*TIMEOUT_US`.
- `HEAD0`, 8'h55: first header byte.
- `HEAD1`, 8'hAA: second header byte.
- `MAX_LEN`, 64: maximum payload length. Legal `LEN` range is 1..MAX_LEN, with MAX_LEN ≤ 255.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rstn` in 1: reset, synchronous and active-low.
- `uart_rdata` in 8: received byte.
- `uart_rdata_valid` in 1: one-cycle strobe; `uart_rdata` is valid in that cycle.
- `uart_rdata_error` in 1: qualified by `uart_rdata_valid`; the byte has a parity or stop-bit error.
- `payload_data` out 8: forwarded payload byte.
- `payload_valid` out 1: one-cycle strobe per payload byte.
- `payload_last` out 1: asserted together with `payload_valid` on byte number LEN.
- `frame_done` out 1: one-cycle end-of-frame strobe.
- `frame_ok` out 1: valid with `frame_done`; 1 means the checksum matched.
- `err_code` out 2: valid with `frame_done`. 0 = ok, 1 = checksum mismatch, 2 = bad LEN, 3 = timeout or line error.

## Operation
- FSM states: IDLE, HEAD, LEN, DATA, CHK. All state and output changes happen only on cycles with `uart_rdata_valid=1`, except timeout handling.
- **IDLE**
  - A byte equal to HEAD0 moves to HEAD.
  - Any other byte, including error bytes, is dropped silently.
- **HEAD**
  - HEAD1 moves to LEN.
  - HEAD0 stays in HEAD (resync).
  - Any other byte, error byte, or timeout returns to IDLE silently, with no `frame_done`.
- **LEN**
  - If the byte is 0 or greater than MAX_LEN: return to IDLE and report `err_code=2`.
  - Otherwise latch `len`, set `cnt=0`, set `sum=LEN`, and move to DATA.
- **DATA**
  - Each byte is output on `payload_data`/`payload_valid`, with `sum=sum+byte` mod 256 and `cnt=cnt+1`.
  - The byte where `cnt==len-1` also asserts `payload_last` and moves to CHK.
- **CHK**
  - Compare the byte with `sum`. Equal gives `frame_ok=1`, `err_code=0`; unequal gives `err_code=1`.
  - Then return to IDLE.
- **Error byte in LEN, DATA or CHK:** the byte is discarded (never forwarded), the FSM returns to IDLE, and `err_code=3` is reported.
- **Timeout:** the gap counter clears on every accepted byte and while in IDLE, and increments every other cycle. When it reaches `TIMEOUT_CYC-1` with no byte in that cycle, the FSM returns to IDLE.
  - From LEN, DATA or CHK this reports `err_code=3`.
  - From HEAD it is silent.
- **Abort mid-payload:** `payload_last` never fires for that frame. The `frame_done` with `frame_ok=0` tells downstream to discard the partial payload.
- **Simultaneous events:** a byte arriving in the same cycle the counter reaches `TIMEOUT_CYC-1` is accepted, and the timeout does not fire.
- **Back-to-back frames:** a HEAD0 byte in the cycle after the CHK byte starts a new frame with no gap needed.

## Timing
- Reset values: FSM in IDLE, counters and sum at 0, and all outputs 0 (`payload_data=8'h00`, `err_code=2'd0`).
- Reset in the middle of a frame aborts it with no `frame_done`.
- Payload latency: `payload_valid` goes high 1 cycle after the corresponding `uart_rdata_valid`.
- `frame_done` goes high 1 cycle after the CHK, bad-LEN or error byte strobe. For a timeout it goes high 1 cycle after the expiry cycle, i.e. `TIMEOUT_CYC+1` cycles after the last byte strobe.
- All strobes are exactly 1 cycle wide.
- `frame_ok` and `err_code` are zero whenever `frame_done=0`.
- No backpressure: downstream must accept one payload byte per `uart_rdata_valid`, which is at most one per UART character time.
- Counter widths: `cnt` and `len` are 8 bits; the gap counter is `$clog2(TIMEOUT_CYC+1)` bits.

## Test plan
- **Good frame:** 55 AA 03 11 22 33 69 → payload 11, 22, 33, with `payload_last` on 33; `frame_done`, `frame_ok=1`, `err_code=0` one cycle after the 69 strobe.
- **Bad checksum:** 55 AA 02 01 02 00 → payload 01, 02; `frame_done`, `frame_ok=0`, `err_code=1`. Then a correct frame 55 AA 01 7F 80 immediately after → `frame_ok=1`.
- **Bad length and resync:**
  - 55 AA 00 → `err_code=2`.
  - 55 AA 41 with MAX_LEN=64 → `err_code=2`.
  - 12 55 55 AA 01 05 06 → leading 12 ignored, double 55 resyncs, `frame_ok=1`.
- **Line error:** 55 AA 03 11, then a byte with `uart_rdata_error=1` → that byte is not forwarded, `frame_done` with `err_code=3`, and no `payload_last`.
- **Timeout** (with TIMEOUT_CYC reduced for simulation):
  - A 55 AA 02 11 stall → `frame_done` `err_code=3` exactly TIMEOUT_CYC+1 cycles after the 11 strobe.
  - A stall after 55 alone → no `frame_done`.
  - A byte landing on the expiry cycle → accepted, no timeout.
- **Reset mid-frame:** `rstn=0` for 1 cycle after 55 AA 03 11 → all outputs 0 and no `frame_done`. A following 55 AA 01 05 06 → `frame_ok=1`.

Source files
------------

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - UART receive-side framer: header sync, cut-through payload, checksum result
module uart_frame_parser #(
  parameter int         CLK_FREQ_MHZ = 100,
  parameter int         TIMEOUT_US   = 1000,
  parameter logic [7:0] HEAD0        = 8'h55,
  parameter logic [7:0] HEAD1        = 8'hAA,
  parameter int         MAX_LEN      = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] uart_rdata,
  input  logic       uart_rdata_valid,
  input  logic       uart_rdata_error,
  output logic [7:0] payload_data,
  output logic       payload_valid,
  output logic       payload_last,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [1:0] err_code
);

  localparam int               TIMEOUT_CYC = CLK_FREQ_MHZ * TIMEOUT_US;
  localparam int               GAP_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_EXPIRE  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
  localparam logic [7:0]       MAX_LEN_B   = 8'(MAX_LEN);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_LINE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       payload_data_q, payload_data_d;
  logic             payload_valid_q, payload_valid_d;
  logic             payload_last_q, payload_last_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_ok_q, frame_ok_d;
  logic [1:0]       err_code_q, err_code_d;

  // State, counters and registered outputs; reset aborts any frame silently
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      sum_q           <= '0;
      gap_q           <= '0;
      payload_data_q  <= '0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_ok_q      <= 1'b0;
      err_code_q      <= ERR_OK;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      sum_q           <= sum_d;
      gap_q           <= gap_d;
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      frame_done_q    <= frame_done_d;
      frame_ok_q      <= frame_ok_d;
      err_code_q      <= err_code_d;
    end
  end

  // Next state and outputs: bytes advance the parser, otherwise only the inter-byte timeout can act
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    sum_d           = sum_q;
    payload_data_d  = payload_data_q;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    frame_done_d    = 1'b0;
    frame_ok_d      = 1'b0;
    err_code_d      = ERR_OK;

    if (state_q == S_IDLE || uart_rdata_valid) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_ONE;
    end

    if (uart_rdata_valid) begin
      case (state_q)
        S_IDLE: begin
          // error bytes never open a frame, even if they look like HEAD0
          if (!uart_rdata_error && uart_rdata == HEAD0) begin
            state_d = S_HEAD;
          end
        end
        S_HEAD: begin
          if (uart_rdata_error) begin
            state_d = S_IDLE;
          end else if (uart_rdata == HEAD1) begin
            state_d = S_LEN;
          end else if (uart_rdata == HEAD0) begin
            state_d = S_HEAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LEN: begin
          if (uart_rdata_error) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            err_code_d   = ERR_LINE;
          end else if (uart_rdata == 8'd0 || uart_rdata > MAX_LEN_B) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            err_code_d   = ERR_LEN;
          end else begin
            len_d   = uart_rdata;
            cnt_d   = 8'd0;
            sum_d   = uart_rdata;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (uart_rdata_error) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            err_code_d   = ERR_LINE;
          end else begin
            payload_data_d  = uart_rdata;
            payload_valid_d = 1'b1;
            sum_d           = sum_q + uart_rdata;
            cnt_d           = cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) begin
              payload_last_d = 1'b1;
              state_d        = S_CHK;
            end
          end
        end
        S_CHK: begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          if (uart_rdata_error) begin
            err_code_d = ERR_LINE;
          end else if (uart_rdata == sum_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_OK;
          end else begin
            err_code_d = ERR_CHK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && gap_q == GAP_EXPIRE) begin
      // a stalled header is just noise; a stalled frame body must be reported
      state_d = S_IDLE;
      gap_d   = '0;
      if (state_q != S_HEAD) begin
        frame_done_d = 1'b1;
        err_code_d   = ERR_LINE;
      end
    end
  end

  assign payload_data  = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign payload_last  = payload_last_q;
  assign frame_done    = frame_done_q;
  assign frame_ok      = frame_ok_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int         T       = 40;
  localparam logic [7:0] H0      = 8'h55;
  localparam logic [7:0] H1      = 8'hAA;
  localparam int         MAXL    = 64;

  logic       clk;
  logic       rstn;
  logic [7:0] uart_rdata;
  logic       uart_rdata_valid;
  logic       uart_rdata_error;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_last;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] err_code;

  uart_frame_parser #(
    .CLK_FREQ_MHZ(1),
    .TIMEOUT_US  (T),
    .HEAD0       (H0),
    .HEAD1       (H1),
    .MAX_LEN     (MAXL)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .uart_rdata      (uart_rdata),
    .uart_rdata_valid(uart_rdata_valid),
    .uart_rdata_error(uart_rdata_error),
    .payload_data    (payload_data),
    .payload_valid   (payload_valid),
    .payload_last    (payload_last),
    .frame_done      (frame_done),
    .frame_ok        (frame_ok),
    .err_code        (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] got_pay[$];
  int         pay_cyc[$];
  logic [2:0] got_frm[$];
  int         frm_cyc[$];
  logic [8:0] exp_pay[$];
  logic [2:0] exp_frm[$];

  logic [7:0] sb[$];
  logic       se[$];
  int         sg[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // output capture plus per-cycle invariants
  always @(negedge clk) begin
    if (payload_valid === 1'b1) begin
      got_pay.push_back({payload_last, payload_data});
      pay_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      got_frm.push_back({frame_ok, err_code});
      frm_cyc.push_back(cyc);
    end else if (rstn) begin
      check("result_zero_without_done", 32'({frame_ok, err_code}), 32'd0);
    end
    if (rstn && payload_valid !== 1'b1) check("last_without_valid", 32'(payload_last), 32'd0);
  end

  task automatic put(input logic [7:0] b, input logic e);
    uart_rdata       = b;
    uart_rdata_valid = 1'b1;
    uart_rdata_error = e;
    @(posedge clk);
    #1;
    uart_rdata_valid = 1'b0;
    uart_rdata_error = 1'b0;
    last_edge        = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    got_pay.delete(); pay_cyc.delete(); got_frm.delete(); frm_cyc.delete();
    exp_pay.delete(); exp_frm.delete();
  endtask

  function automatic logic [2:0] frm(input logic [1:0] e);
    return {(e == 2'd0), e};
  endfunction

  task automatic compare_run(input string tag);
    int n;
    check({tag, " payload_count"}, 32'(got_pay.size()), 32'(exp_pay.size()));
    n = (got_pay.size() < exp_pay.size()) ? got_pay.size() : exp_pay.size();
    for (int i = 0; i < n; i++) check({tag, " payload_byte"}, 32'(got_pay[i]), 32'(exp_pay[i]));
    check({tag, " frame_count"}, 32'(got_frm.size()), 32'(exp_frm.size()));
    n = (got_frm.size() < exp_frm.size()) ? got_frm.size() : exp_frm.size();
    for (int i = 0; i < n; i++) check({tag, " frame_result"}, 32'(got_frm[i]), 32'(exp_frm[i]));
  endtask

  // Reference: scan the whole byte list for frames by index arithmetic; a list that ends
  // mid-frame is followed by a long idle, so it times out (silently if only the header was seen)
  task automatic model();
    int i, j, k, n, L;
    logic [7:0] s;
    bit done;
    n = sb.size();
    i = 0;
    while (i < n) begin
      if (se[i] || sb[i] != H0) begin i++; continue; end
      j = i + 1;
      while (j < n && !se[j] && sb[j] == H0) j++;
      if (j >= n) break;
      if (se[j] || sb[j] != H1) begin i = j + 1; continue; end
      k = j + 1;
      if (k >= n) begin exp_frm.push_back(frm(2'd3)); break; end
      if (se[k]) begin exp_frm.push_back(frm(2'd3)); i = k + 1; continue; end
      L = int'(sb[k]);
      if (L == 0 || L > MAXL) begin exp_frm.push_back(frm(2'd2)); i = k + 1; continue; end
      s = sb[k];
      done = 0;
      for (int m = 0; m < L; m++) begin
        if (k + 1 + m >= n) begin exp_frm.push_back(frm(2'd3)); i = n; done = 1; break; end
        if (se[k + 1 + m]) begin exp_frm.push_back(frm(2'd3)); i = k + 2 + m; done = 1; break; end
        exp_pay.push_back({(m == L - 1), sb[k + 1 + m]});
        s = s + sb[k + 1 + m];
      end
      if (done) continue;
      if (k + 1 + L >= n) begin exp_frm.push_back(frm(2'd3)); break; end
      if (se[k + 1 + L]) exp_frm.push_back(frm(2'd3));
      else exp_frm.push_back(frm((sb[k + 1 + L] == s) ? 2'd0 : 2'd1));
      i = k + 2 + L;
    end
  endtask

  task automatic add(input logic [7:0] b);
    sb.push_back(b);
    se.push_back($urandom_range(0, 39) == 0);
    sg.push_back($urandom_range(0, 3));
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    logic [7:0]  errm;
    int          np;
    logic [31:0] pay;
    logic        last;
    int          nf;
    logic [1:0]  err;
  } vec_t;

  vec_t tv[11];

  initial begin
    logic [63:0] tb_bytes;
    logic [31:0] tb_pay;
    logic [7:0]  s;
    int          e0, e1, L;

    tv[0]  = '{7, 64'h0069_3322_1103_AA55, 8'h00, 3, 32'h0033_2211, 1'b1, 1, 2'd0};
    tv[1]  = '{6, 64'h0000_0002_0102_AA55, 8'h00, 2, 32'h0000_0201, 1'b1, 1, 2'd1};
    tv[2]  = '{5, 64'h0000_0080_7F01_AA55, 8'h00, 1, 32'h0000_007F, 1'b1, 1, 2'd0};
    tv[3]  = '{3, 64'h0000_0000_0000_AA55, 8'h00, 0, 32'h0,        1'b0, 1, 2'd2};
    tv[4]  = '{3, 64'h0000_0000_0041_AA55, 8'h00, 0, 32'h0,        1'b0, 1, 2'd2};
    tv[5]  = '{7, 64'h0006_0501_AA55_5512, 8'h00, 1, 32'h0000_0005, 1'b1, 1, 2'd0};
    tv[6]  = '{5, 64'h0000_00EE_1103_AA55, 8'h10, 1, 32'h0000_0011, 1'b0, 1, 2'd3};
    tv[7]  = '{6, 64'h0000_3322_1102_AA55, 8'h20, 2, 32'h0000_2211, 1'b1, 1, 2'd3};
    tv[8]  = '{2, 64'h0000_0000_0000_1255, 8'h00, 0, 32'h0,        1'b0, 0, 2'd0};
    tv[9]  = '{5, 64'h0000_0000_FF01_AA55, 8'h00, 1, 32'h0000_00FF, 1'b1, 1, 2'd0};
    tv[10] = '{3, 64'h0000_0000_00FF_AA55, 8'h00, 0, 32'h0,        1'b0, 1, 2'd2};

    rstn = 1'b0;
    uart_rdata = 8'h00;
    uart_rdata_valid = 1'b0;
    uart_rdata_error = 1'b0;
    idle(3);
    check("reset payload_data", 32'(payload_data), 32'd0);
    check("reset payload_valid", 32'(payload_valid), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    rstn = 1'b1;
    idle(2);

    // table vectors
    for (int r = 0; r < 11; r++) begin
      clear_all();
      tb_bytes = tv[r].bytes;
      tb_pay   = tv[r].pay;
      for (int i = 0; i < tv[r].n; i++) begin
        put(tb_bytes[8*i +: 8], tv[r].errm[i]);
        idle(1);
      end
      idle(T + 5);
      for (int i = 0; i < tv[r].np; i++)
        exp_pay.push_back({(tv[r].last && i == tv[r].np - 1), tb_pay[8*i +: 8]});
      if (tv[r].nf == 1) exp_frm.push_back(frm(tv[r].err));
      compare_run($sformatf("vec%0d", r));
    end

    // back-to-back frames with no idle cycles at all
    clear_all();
    put(8'h55, 0); put(8'hAA, 0); put(8'h02, 0); put(8'h01, 0); put(8'h02, 0); put(8'h00, 0);
    put(8'h55, 0); put(8'hAA, 0); put(8'h01, 0); put(8'h7F, 0); put(8'h80, 0);
    idle(T + 5);
    exp_pay = '{9'h001, 9'h102, 9'h17F};
    exp_frm = '{frm(2'd1), frm(2'd0)};
    compare_run("back_to_back");

    // latency: payload and frame_done one cycle after their strobes
    clear_all();
    put(8'h55, 0); put(8'hAA, 0); put(8'h01, 0); idle(2);
    put(8'h05, 0); e0 = last_edge; idle(2);
    put(8'h06, 0); e1 = last_edge; idle(3);
    check("latency payload_count", 32'(pay_cyc.size()), 32'd1);
    check("latency frame_count", 32'(frm_cyc.size()), 32'd1);
    if (pay_cyc.size() > 0) check("latency payload", 32'(pay_cyc[0] - e0), 32'd0);
    if (frm_cyc.size() > 0) check("latency frame_done", 32'(frm_cyc[0] - e1), 32'd0);

    // timeout inside payload: report exactly T+1 cycles after the last strobe
    clear_all();
    put(8'h55, 0); put(8'hAA, 0); put(8'h02, 0); put(8'h11, 0); e0 = last_edge;
    idle(T + 5);
    exp_pay = '{9'h011};
    exp_frm = '{frm(2'd3)};
    compare_run("timeout");
    if (frm_cyc.size() > 0) check("timeout delay", 32'(frm_cyc[0] - e0), 32'(T));

    // stall after lone header byte is silent
    clear_all();
    put(8'h55, 0);
    idle(T + 5);
    compare_run("head_stall");

    // byte landing on the expiry cycle is accepted
    clear_all();
    put(8'h55, 0); put(8'hAA, 0); put(8'h02, 0); put(8'h11, 0);
    idle(T - 1);
    put(8'h22, 0); put(8'h35, 0);
    idle(T + 5);
    exp_pay = '{9'h011, 9'h122};
    exp_frm = '{frm(2'd0)};
    compare_run("expiry_edge");

    // maximum length payload
    clear_all();
    L = MAXL;
    s = 8'(L);
    put(H0, 0); put(H1, 0); put(8'(L), 0);
    for (int i = 0; i < L; i++) begin
      put(8'(i * 7 + 3), 0);
      exp_pay.push_back({(i == L - 1), 8'(i * 7 + 3)});
      s = s + 8'(i * 7 + 3);
    end
    put(s, 0);
    idle(T + 5);
    exp_frm = '{frm(2'd0)};
    compare_run("max_len");

    // reset in mid-frame
    clear_all();
    put(8'h55, 0); put(8'hAA, 0); put(8'h03, 0); put(8'h11, 0);
    rstn = 1'b0;
    idle(1);
    check("midreset payload_data", 32'(payload_data), 32'd0);
    check("midreset payload_valid", 32'(payload_valid), 32'd0);
    check("midreset payload_last", 32'(payload_last), 32'd0);
    check("midreset frame_done", 32'(frame_done), 32'd0);
    check("midreset frame_ok", 32'(frame_ok), 32'd0);
    check("midreset err_code", 32'(err_code), 32'd0);
    rstn = 1'b1;
    clear_all();
    idle(T + 5);
    compare_run("midreset_quiet");
    put(8'h55, 0); put(8'hAA, 0); put(8'h01, 0); put(8'h05, 0); put(8'h06, 0);
    idle(3);
    exp_pay = '{9'h105};
    exp_frm = '{frm(2'd0)};
    compare_run("after_reset");

    // randomized byte streams against the reference scanner
    for (int round = 0; round < 3; round++) begin
      clear_all();
      sb.delete(); se.delete(); sg.delete();
      while (sb.size() < 300) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) add(8'($urandom_range(0, 255)));
        else if (r == 1) add(H0);
        else begin
          if (r == 2) L = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(65, 255);
          else L = $urandom_range(1, 6);
          add(H0); add(H1); add(8'(L));
          s = 8'(L);
          if (L <= MAXL) begin
            for (int i = 0; i < L; i++) begin
              logic [7:0] b;
              b = 8'($urandom_range(0, 255));
              add(b);
              s = s + b;
            end
          end
          if ($urandom_range(0, 4) == 0) s = s ^ 8'h5A;
          add(s);
        end
      end
      for (int i = 0; i < sb.size(); i++) begin
        put(sb[i], se[i]);
        if (sg[i] > 0) idle(sg[i]);
      end
      idle(T + 5);
      model();
      compare_run($sformatf("random%0d", round));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
